// File: rtl/spi_txn_arbiter_if.sv
// Signal bundle between spi_txn_arbiter, its client requesters and the shared SPI master.
// The arbiter takes the slave view; the environment (clients plus SPI master) takes the master view.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 12
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic                      spi_new_data;
    logic [DATA_W-1:0]         spi_din;
    logic                      spi_done;
    logic [DATA_W-1:0]         spi_dout;
    logic                      busy;

    modport slave (
        input  req, req_data, spi_done, spi_dout,
        output gnt, rsp_valid, rsp_data, rsp_err, spi_new_data, spi_din, busy
    );

    modport master (
        output req, req_data, spi_done, spi_dout,
        input  gnt, rsp_valid, rsp_data, rsp_err, spi_new_data, spi_din, busy
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, with a per-transaction
// timeout. Every output is a register; one transaction is in flight at a time.
module spi_txn_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    spi_txn_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    ptr_d;
    logic [IDX_W-1:0]    win_idx_s;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic                spi_new_data_q;
    logic [DATA_W-1:0]   spi_din_q;
    logic                busy_q;

    // First set request found scanning ptr, ptr+1, ... with wrap; the lowest offset wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W:0]   cand;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end else begin
                cand = cand;
            end
            if (req[cand[IDX_W-1:0]]) begin
                pick = cand[IDX_W-1:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Winner of the current request vector and the pointer that follows the active winner.
    always_comb begin
        win_idx_s = rr_pick(bus.req, ptr_q);
        if (idx_q == IDX_LAST) begin
            ptr_d = {IDX_W{1'b0}};
        end else begin
            ptr_d = idx_q + IDX_W'(1);
        end
    end

    // Transaction FSM; outputs lead the state so that grant/start/response meet their latencies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= {IDX_W{1'b0}};
            ptr_q          <= {IDX_W{1'b0}};
            cnt_q          <= {CNT_W{1'b0}};
            gnt_q          <= {NUM_REQ{1'b0}};
            rsp_valid_q    <= {NUM_REQ{1'b0}};
            rsp_data_q     <= {DATA_W{1'b0}};
            rsp_err_q      <= 1'b0;
            spi_new_data_q <= 1'b0;
            spi_din_q      <= {DATA_W{1'b0}};
            busy_q         <= 1'b0;
        end else begin
            rsp_valid_q    <= {NUM_REQ{1'b0}};
            spi_new_data_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        idx_q     <= win_idx_s;
                        spi_din_q <= bus.req_data[int'(win_idx_s) * DATA_W +: DATA_W];
                        gnt_q     <= NUM_REQ'(1) << win_idx_s;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    spi_new_data_q <= 1'b1;
                    cnt_q          <= {CNT_W{1'b0}};
                    state_q        <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A completion in the timeout cycle still counts as a completion.
                    if (bus.spi_done) begin
                        rsp_data_q  <= bus.spi_dout;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= NUM_REQ'(1) << idx_q;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_data_q  <= {DATA_W{1'b0}};
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= NUM_REQ'(1) << idx_q;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    gnt_q   <= {NUM_REQ{1'b0}};
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= {NUM_REQ{1'b0}};
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.spi_new_data = spi_new_data_q;
    assign bus.spi_din      = spi_din_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: instance A (TIMEOUT=255) and instance B (TIMEOUT=8)
// share one stimulus/observation path selected by sel.
module tb_spi_txn_arbiter;
    logic clk;
    logic reset;

    spi_txn_arbiter_if #(.NUM_REQ(4), .DATA_W(12)) bus_a ();
    spi_txn_arbiter_if #(.NUM_REQ(4), .DATA_W(12)) bus_b ();

    spi_txn_arbiter #(.NUM_REQ(4), .DATA_W(12), .TIMEOUT(255)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    spi_txn_arbiter #(.NUM_REQ(4), .DATA_W(12), .TIMEOUT(8)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    logic        sel;
    logic [3:0]  t_req;
    logic [47:0] t_data;
    logic        t_done;
    logic [11:0] t_dout;

    assign bus_a.req      = sel ? 4'b0000 : t_req;
    assign bus_a.req_data = sel ? 48'h0 : t_data;
    assign bus_a.spi_done = sel ? 1'b0 : t_done;
    assign bus_a.spi_dout = sel ? 12'h000 : t_dout;
    assign bus_b.req      = sel ? t_req : 4'b0000;
    assign bus_b.req_data = sel ? t_data : 48'h0;
    assign bus_b.spi_done = sel ? t_done : 1'b0;
    assign bus_b.spi_dout = sel ? t_dout : 12'h000;

    logic [3:0]  o_gnt, o_rv;
    logic [11:0] o_rdata, o_din;
    logic        o_err, o_new, o_busy;
    assign o_gnt   = sel ? bus_b.gnt : bus_a.gnt;
    assign o_rv    = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign o_rdata = sel ? bus_b.rsp_data : bus_a.rsp_data;
    assign o_din   = sel ? bus_b.spi_din : bus_a.spi_din;
    assign o_err   = sel ? bus_b.rsp_err : bus_a.rsp_err;
    assign o_new   = sel ? bus_b.spi_new_data : bus_a.spi_new_data;
    assign o_busy  = sel ? bus_b.busy : bus_a.busy;

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the start pulse, check the launched word, answer after 'delay' edges, check the response.
    task automatic serve(input string tag, input int idx, input logic [11:0] din,
                         input logic [11:0] dout, input int delay);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        n = 0;
        while (o_new !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, 32'(o_new), 32'd1);
        chk({tag, "_gnt"}, 32'(o_gnt), 32'(oh));
        chk({tag, "_din"}, 32'(o_din), 32'(din));
        tick();
        chk({tag, "_pulse_once"}, 32'(o_new), 32'd0);
        repeat (delay - 2) tick();
        t_done = 1'b1;
        t_dout = dout;
        tick();
        t_done = 1'b0;
        chk({tag, "_rsp_valid"}, 32'(o_rv), 32'(oh));
        chk({tag, "_rsp_data"}, 32'(o_rdata), 32'(dout));
        chk({tag, "_rsp_err"}, 32'(o_err), 32'd0);
        chk({tag, "_gnt_in_resp"}, 32'(o_gnt), 32'(oh));
        tick();
        chk({tag, "_rsp_clear"}, 32'(o_rv), 32'd0);
        chk({tag, "_idle_gap"}, 32'(o_gnt), 32'd0);
    endtask

    initial begin
        int n;
        sel    = 1'b0;
        t_req  = 4'b0000;
        t_data = 48'h0;
        t_done = 1'b0;
        t_dout = 12'h000;
        reset  = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_rv", 32'(o_rv), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_new", 32'(o_new), 32'd0);
        chk("rst_din", 32'(o_din), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        reset = 1'b1;
        tick();

        // Test 1: single request, latency and a 20-cycle answer.
        t_data[11:0] = 12'd5;
        t_req = 4'b0001;
        tick();
        chk("t1_gnt_lat", 32'(o_gnt), 32'h1);
        chk("t1_new_not_yet", 32'(o_new), 32'd0);
        chk("t1_busy", 32'(o_busy), 32'd1);
        tick();
        chk("t1_new_lat", 32'(o_new), 32'd1);
        serve("t1", 0, 12'd5, 12'hABC, 20);
        t_req = 4'b0000;
        tick();
        chk("t1_busy_idle", 32'(o_busy), 32'd0);

        // Test 2: two requesters held; pointer starts at 1 after test 1.
        t_data[23:12] = 12'h111;
        t_data[35:24] = 12'h222;
        t_req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) serve("t2_r1", 1, 12'h111, 12'h400 + 12'(i), 3);
            else            serve("t2_r2", 2, 12'h222, 12'h400 + 12'(i), 3);
        end
        t_req = 4'b0000;

        // Test 3: fresh pointer, all four requesting.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) t_data[k*12 +: 12] = 12'h0A0 + 12'(k);
        t_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve("t3", i % 4, 12'h0A0 + 12'(i % 4), 12'h500 + 12'(i), 3);
        end
        t_req = 4'b0000;

        // Test 5: reset while waiting aborts the transaction and clears the pointer (was 1).
        t_data[23:12] = 12'h321;
        t_req = 4'b0010;
        n = 0;
        while (o_new !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t5_start", 32'(o_new), 32'd1);
        chk("t5_gnt", 32'(o_gnt), 32'h2);
        tick();
        tick();
        reset = 1'b0;
        t_req = 4'b0000;
        #1;
        chk("t5_async_gnt", 32'(o_gnt), 32'd0);
        chk("t5_async_busy", 32'(o_busy), 32'd0);
        tick();
        chk("t5_no_rv", 32'(o_rv), 32'd0);
        chk("t5_rdata", 32'(o_rdata), 32'd0);
        chk("t5_din", 32'(o_din), 32'd0);
        reset = 1'b1;
        t_data[11:0]  = 12'h100;
        t_data[47:36] = 12'h300;
        t_req = 4'b1001;
        serve("t5_ptr0", 0, 12'h100, 12'h0B1, 3);
        t_data[35:24] = 12'h200;
        t_req = 4'b0100;
        serve("t5_r2", 2, 12'h200, 12'h0B2, 3);
        t_req = 4'b0000;

        // Test 4: instance B times out after 8 cycles, then serves normally.
        sel = 1'b1;
        tick();
        t_data[11:0] = 12'h0F0;
        t_req = 4'b0001;
        serve("t4_pre", 0, 12'h0F0, 12'h5A5, 3);
        n = 0;
        while (o_new !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t4_start", 32'(o_new), 32'd1);
        n = 0;
        while (o_rv === 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", 32'(n), 32'd8);
        chk("t4_rv", 32'(o_rv), 32'h1);
        chk("t4_err", 32'(o_err), 32'd1);
        chk("t4_rdata", 32'(o_rdata), 32'd0);
        tick();
        serve("t4_post", 0, 12'h0F0, 12'h3C3, 4);
        t_req = 4'b0000;
        tick();

        // Test 6: stray done in IDLE is ignored; done in the timeout cycle wins.
        t_done = 1'b1;
        t_dout = 12'h777;
        tick();
        t_done = 1'b0;
        chk("t6_stray_busy", 32'(o_busy), 32'd0);
        chk("t6_stray_rv", 32'(o_rv), 32'd0);
        chk("t6_stray_rdata", 32'(o_rdata), 32'h3C3);
        tick();
        chk("t6_stray_still_idle", 32'(o_busy), 32'd0);
        t_data[23:12] = 12'h0AA;
        t_req = 4'b0010;
        serve("t6_coincident", 1, 12'h0AA, 12'h6E6, 8);
        t_req = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
